// File: rtl/div_ratio_checker.sv
// ---------------------------------------------------------------------------
// div_ratio_checker
//
// Receive-side self-check for a divided clock. q_in is a divided version of
// clk, generated in the same clock domain. The block measures every
// rise-to-rise period of q_in in clk cycles, together with the number of
// cycles q_in was sampled high and low inside that period. Each period is
// compared against the expected divide ratio DIV. After LOCK_CNT consecutive
// matching periods the block reports lock. Wrong periods and missing edges are
// flagged with single-cycle pulses.
//
// Parameters
//   DIV       expected period of q_in in clk cycles (2 .. 2^CNT_W-2)
//   CNT_W     width of the measurement counters and result outputs
//   LOCK_CNT  consecutive matching periods needed for lock (1 .. 15)
//
// Ports
//   clk           system clock; q_in is synchronous to it
//   reset         asynchronous, active-low reset
//   en            measurement enable; low forces the idle state
//   q_in          divided clock under test
//   period        last measured rise-to-rise period, in clk cycles
//   high_time     cycles q_in was sampled 1 during the last period
//   low_time      cycles q_in was sampled 0 during the last period
//   period_valid  one-cycle pulse: period/high_time/low_time were updated
//   locked        level: the last LOCK_CNT periods all equalled DIV
//   err_ratio     one-cycle pulse: the measured period differed from DIV
//   err_timeout   one-cycle pulse: no rising edge for 2^CNT_W-1 cycles
// ---------------------------------------------------------------------------
module div_ratio_checker #(
    parameter int unsigned DIV      = 3,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             q_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time,
    output logic             period_valid,
    output logic             locked,
    output logic             err_ratio,
    output logic             err_timeout
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    // The period counter never goes past this value: reaching it without a
    // rising edge is a timeout, so the counter cannot wrap.
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DivVal  = CNT_W'(DIV);
    localparam logic [3:0]       LockMax = 4'(LOCK_CNT);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        StIdle,     // disabled, nothing measured
        StSeek,     // waiting for the first rising edge of a run
        StMeasure   // counting between rising edges
    } state_e;

    state_e           state_q, state_d;

    logic             q_d;          // q_in delayed by one clk, for edge detect
    logic             rise;

    logic [CNT_W-1:0] cnt_q, cnt_d;         // cycles since the last rise
    logic [CNT_W-1:0] hcnt_q, hcnt_d;       // high samples since the last rise
    logic [3:0]       match_q, match_d;     // consecutive matching periods
    logic [3:0]       match_inc;

    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             eratio_q, eratio_d;
    logic             etime_q, etime_d;

    // -----------------------------------------------------------------------
    // Edge detection
    // -----------------------------------------------------------------------
    assign rise = q_in & ~q_d;

    // Match counter saturates at LOCK_CNT so a long locked run cannot overflow.
    always_comb begin
        if (match_q >= LockMax) begin
            match_inc = LockMax;
        end else begin
            match_inc = match_q + 4'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        match_d  = match_q;
        period_d = period_q;
        high_d   = high_q;
        low_d    = low_q;
        locked_d = locked_q;
        valid_d  = 1'b0;
        eratio_d = 1'b0;
        etime_d  = 1'b0;

        if (!en) begin
            // Disabling drops lock and discards the period in progress, but
            // the last reported measurement stays visible.
            state_d  = StIdle;
            cnt_d    = '0;
            hcnt_d   = '0;
            match_d  = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    // A rise in this cycle is ignored; the run starts from
                    // the next rising edge seen in StSeek.
                    state_d = StSeek;
                    cnt_d   = '0;
                    hcnt_d  = '0;
                end

                StSeek: begin
                    // First edge of a run only opens a period; nothing is
                    // reported because no complete period has been seen.
                    if (rise) begin
                        cnt_d   = CntOne;
                        hcnt_d  = CntOne;
                        state_d = StMeasure;
                    end
                end

                StMeasure: begin
                    if (rise) begin
                        period_d = cnt_q;
                        high_d   = hcnt_q;
                        low_d    = cnt_q - hcnt_q;
                        valid_d  = 1'b1;
                        // The rise cycle itself is the first (high) sample of
                        // the next period.
                        cnt_d    = CntOne;
                        hcnt_d   = CntOne;
                        if (cnt_q == DivVal) begin
                            match_d = match_inc;
                            if (match_inc == LockMax) begin
                                locked_d = 1'b1;
                            end
                        end else begin
                            eratio_d = 1'b1;
                            match_d  = '0;
                            locked_d = 1'b0;
                        end
                    end else if (cnt_q == CntMax) begin
                        // Stuck or missing edge: give up on this period and
                        // look for a fresh edge without a deadline.
                        etime_d  = 1'b1;
                        locked_d = 1'b0;
                        match_d  = '0;
                        cnt_d    = '0;
                        hcnt_d   = '0;
                        state_d  = StSeek;
                    end else begin
                        cnt_d  = cnt_q + CntOne;
                        hcnt_d = hcnt_q + {{(CNT_W-1){1'b0}}, q_in};
                    end
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            q_d      <= 1'b0;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            match_q  <= '0;
            period_q <= '0;
            high_q   <= '0;
            low_q    <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            eratio_q <= 1'b0;
            etime_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_d      <= q_in;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            match_q  <= match_d;
            period_q <= period_d;
            high_q   <= high_d;
            low_q    <= low_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            eratio_q <= eratio_d;
            etime_q  <= etime_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign period       = period_q;
    assign high_time    = high_q;
    assign low_time     = low_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign err_ratio    = eratio_q;
    assign err_timeout  = etime_q;

endmodule

// File: tb/tb_div_ratio_checker.sv
// ---------------------------------------------------------------------------
// tb_div_ratio_checker
//
// Drives q_in as sequences of whole periods (length, high time), plus enable
// drops, asynchronous resets and long stuck levels. A reference model keeps
// the full history of q_in samples and derives each expected measurement from
// the cycle index of consecutive rising edges and a sum over that history.
// All DUT outputs are compared 1 time unit after every rising clk edge.
// ---------------------------------------------------------------------------
module tb_div_ratio_checker;

    localparam int unsigned DIV      = 3;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned LOCK_CNT = 4;
    localparam int          TMO      = (1 << CNT_W) - 1;
    localparam int          HIST     = 65536;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             q_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] low_time;
    logic             period_valid;
    logic             locked;
    logic             err_ratio;
    logic             err_timeout;

    div_ratio_checker #(
        .DIV      (DIV),
        .CNT_W    (CNT_W),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .q_in         (q_in),
        .period       (period),
        .high_time    (high_time),
        .low_time     (low_time),
        .period_valid (period_valid),
        .locked       (locked),
        .err_ratio    (err_ratio),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    bit hist [HIST];
    int cyc;          // index of the current clk edge
    bit prev_q;       // q_in at the previous edge (0 after reset)
    bit armed;        // one enabled edge has passed since enable/reset
    bit have_ref;     // a reference rising edge is open
    int ref_cyc;      // edge index of that reference rise
    int good_run;     // consecutive periods equal to DIV, capped at LOCK_CNT

    int exp_period, exp_high, exp_low;
    bit exp_valid, exp_locked, exp_eratio, exp_etime;

    function automatic int ones_between(input int a, input int b);
        int s = 0;
        for (int i = a; i < b; i++) s += int'(hist[i % HIST]);
        return s;
    endfunction

    task automatic model_reset();
        prev_q     = 1'b0;
        armed      = 1'b0;
        have_ref   = 1'b0;
        good_run   = 0;
        exp_period = 0;
        exp_high   = 0;
        exp_low    = 0;
        exp_valid  = 1'b0;
        exp_locked = 1'b0;
        exp_eratio = 1'b0;
        exp_etime  = 1'b0;
    endtask

    task automatic model_step();
        bit r;
        int len;
        exp_valid  = 1'b0;
        exp_eratio = 1'b0;
        exp_etime  = 1'b0;
        if (!reset) begin
            model_reset();
        end else begin
            hist[cyc % HIST] = q_in;
            r      = q_in && !prev_q;
            prev_q = q_in;
            if (!en) begin
                armed      = 1'b0;
                have_ref   = 1'b0;
                good_run   = 0;
                exp_locked = 1'b0;
            end else if (!armed) begin
                armed = 1'b1;
            end else if (r) begin
                if (have_ref) begin
                    len        = cyc - ref_cyc;
                    exp_period = len;
                    exp_high   = ones_between(ref_cyc, cyc);
                    exp_low    = len - exp_high;
                    exp_valid  = 1'b1;
                    if (len == DIV) begin
                        good_run   = (good_run < LOCK_CNT) ? good_run + 1 : LOCK_CNT;
                        exp_locked = (good_run == LOCK_CNT);
                    end else begin
                        exp_eratio = 1'b1;
                        good_run   = 0;
                        exp_locked = 1'b0;
                    end
                end
                have_ref = 1'b1;
                ref_cyc  = cyc;
            end else if (have_ref && (cyc - ref_cyc == TMO)) begin
                exp_etime  = 1'b1;
                have_ref   = 1'b0;
                good_run   = 0;
                exp_locked = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic compare_all();
        check("period",       int'(period),       exp_period);
        check("high_time",    int'(high_time),    exp_high);
        check("low_time",     int'(low_time),     exp_low);
        check("period_valid", int'(period_valid), int'(exp_valid));
        check("locked",       int'(locked),       int'(exp_locked));
        check("err_ratio",    int'(err_ratio),    int'(exp_eratio));
        check("err_timeout",  int'(err_timeout),  int'(exp_etime));
    endtask

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic drive_cycle(input bit e, input bit q);
        en   = e;
        q_in = q;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic gen_period(input int len, input int high);
        for (int i = 0; i < len; i++) drive_cycle(1'b1, i < high);
    endtask

    // Pull reset low between edges, check the immediate clear, hold it for a
    // couple of edges and release it before the next call returns to stimulus.
    task automatic pulse_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        drive_cycle(1'b1, 1'b0);
        drive_cycle(1'b1, 1'b1);
        reset = 1'b1;
    endtask

    // -----------------------------------------------------------------------
    // Test sequence
    // -----------------------------------------------------------------------
    initial begin
        int r;
        int len;
        reset = 1'b0;
        en    = 1'b0;
        q_in  = 1'b0;
        cyc   = 0;
        model_reset();
        #3;
        compare_all();
        drive_cycle(1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0);
        reset = 1'b1;

        // Ideal /3, lock after four reported periods.
        for (int i = 0; i < 10; i++) gen_period(3, 1);
        check("locked_after_ideal", int'(locked), 1);

        // One long period breaks lock, then relock.
        gen_period(4, 1);
        for (int i = 0; i < 8; i++) gen_period(3, 1);

        // Stuck low: timeout, then relock.
        gen_period(300, 1);
        for (int i = 0; i < 8; i++) gen_period(3, 1);

        // Stuck high.
        gen_period(280, 280);
        for (int i = 0; i < 8; i++) gen_period(3, 1);

        // Boundary: rise exactly at the timeout count, and one cycle later.
        gen_period(TMO, 1);
        gen_period(TMO + 1, 1);
        for (int i = 0; i < 6; i++) gen_period(3, 1);

        // Reset mid-measurement while locked.
        drive_cycle(1'b1, 1'b1);
        pulse_reset();
        for (int i = 0; i < 8; i++) gen_period(3, 1);

        // Enable dropped for 10 cycles while locked; q_in keeps toggling.
        for (int i = 0; i < 10; i++) drive_cycle(1'b0, (i % 3) == 0);
        for (int i = 0; i < 8; i++) gen_period(3, 1);

        // 50% duty at twice the expected period.
        for (int i = 0; i < 6; i++) gen_period(6, 3);
        check("locked_wrong_ratio", int'(locked), 0);

        // Randomized mix.
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 50) begin
                gen_period(3, 1);
            end else if (r < 62) begin
                gen_period(3, int'($urandom_range(1, 2)));
            end else if (r < 76) begin
                len = int'($urandom_range(2, 12));
                gen_period(len, int'($urandom_range(1, len - 1)));
            end else if (r < 86) begin
                len = int'($urandom_range(1, 6));
                for (int i = 0; i < len; i++) drive_cycle(1'b0, 1'($urandom_range(0, 1)));
            end else if (r < 90) begin
                pulse_reset();
            end else if (r < 94) begin
                len = int'($urandom_range(TMO - 4, TMO + 4));
                gen_period(len, int'($urandom_range(1, 3)));
            end else begin
                for (int i = 0; i < 12; i++) begin
                    drive_cycle(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_ratio_checker.md
Name: div_ratio_checker

Overview:
Receive-side companion to the team's clock dividers. Samples a divided clock (q_in) generated from the same clk, measures its period, high time and low time in clk cycles, and checks the period against the expected divide ratio DIV. Asserts locked after LOCK_CNT consecutive matching periods. Flags ratio mismatches and stuck/missing edges, for use as an on-chip self-check of divider outputs.

Parameters:
DIV, 3, expected period of q_in in clk cycles (2..2^CNT_W-2)
CNT_W, 8, width of measurement counters and outputs
LOCK_CNT, 4, consecutive matching periods required to assert locked (1..15)

Ports:
clk  input  1  system clock; q_in is synchronous to it
reset  input  1  asynchronous, active-low reset
en  input  1  measurement enable
q_in  input  1  divided clock under test
period  output  CNT_W  last measured rise-to-rise period, clk cycles
high_time  output  CNT_W  cycles q_in sampled 1 in last period
low_time  output  CNT_W  cycles q_in sampled 0 in last period (period - high_time)
period_valid  output  1  one-cycle pulse: period/high_time/low_time updated
locked  output  1  level: LOCK_CNT consecutive periods equal DIV
err_ratio  output  1  one-cycle pulse: measured period != DIV
err_timeout  output  1  one-cycle pulse: no rising edge within 2^CNT_W-1 cycles

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, q_d=0, cnt=0, hcnt=0, match_cnt=0.
- Edge detect: q_d <= q_in every clk; rise = q_in & ~q_d, evaluated at each clk edge.
- States: IDLE, SEEK, MEASURE.
- IDLE: en=1 -> SEEK next cycle. No measurement.
- SEEK: on rise, cnt<=1, hcnt<=1, -> MEASURE. No period_valid on this first edge.
- MEASURE, no rise: cnt<=cnt+1; hcnt<=hcnt+q_in.
- MEASURE, rise: period<=cnt, high_time<=hcnt, low_time<=cnt-hcnt, period_valid<=1 (all registered, visible the cycle after the rise edge). Then cnt<=1, hcnt<=1.
- Period example: q_in rising every 3 clks gives period=3.
- Ratio check on the same rise:
  - cnt==DIV: match_cnt<=min(match_cnt+1, LOCK_CNT); locked<=1 when the new match_cnt reaches LOCK_CNT. locked asserts the same cycle as that period_valid.
  - cnt!=DIV: err_ratio pulse, match_cnt<=0, locked<=0, same cycle as period_valid.
- Timeout: in MEASURE, cnt==2^CNT_W-1 and no rise -> err_timeout pulse, locked<=0, match_cnt<=0, cnt<=0, -> SEEK. No period_valid. In SEEK there is no timeout; waiting is indefinite.
- en=0 in any state: -> IDLE next cycle, locked<=0, match_cnt<=0, pulses 0. period/high_time/low_time hold their last values. A rise coincident with en falling is ignored.
- en re-asserted: restarts at SEEK. The first period after a restart is not reported.
- Pulses (period_valid, err_ratio, err_timeout) are exactly one cycle and never assert in IDLE/SEEK, except err_timeout on the transition out of MEASURE.
- q_in held constant 1 or 0 while in MEASURE: timeout path applies.
- Reset asserted mid-period: immediate clear. First rise after release is treated as a SEEK edge.
- Arithmetic: unsigned, CNT_W bits, cnt saturates at 2^CNT_W-1 via the timeout rule, so it never wraps.

Test Plan:
- DIV=3, LOCK_CNT=4; q_in = ideal /3 (high 1, low 2), en=1 -> period_valid every 3 clks with period=3, high_time=1, low_time=2; locked rises on the 4th period_valid; no errors.
- Locked, then one period of 4 clks injected -> err_ratio pulse with period=4, locked falls that cycle; relocks after 4 further good periods.
- Locked, then q_in held 0; CNT_W=8 -> err_timeout exactly 255 cycles after the last rise, locked=0, no period_valid; resumed /3 input relocks after 4 reported periods.
- Reset pulled low mid-measurement while locked -> all outputs 0 immediately; after release, first rise yields no period_valid, second rise yields period=3.
- en dropped for 10 cycles while locked -> locked=0 next cycle, period/high_time/low_time hold 3/1/2, no pulses; on re-enable the first reported period comes at the 2nd rise.
- q_in with 50% duty, period 6 (DIV=3) -> period=6, high_time=3, low_time=3, err_ratio on every period_valid, locked stays 0.
